// File: rtl/gyro_uart_pkg.sv
// rtl/gyro_uart_pkg.sv - shared constants and state enums for the gyro frame receiver
// Purpose: default UART timing, frame trailer definition, payload length and
//          the state encodings used by uart_rx_byte and gyro_frame_rx.
// Ports:   none (package)
package gyro_uart_pkg;

   localparam int         DEF_CLKS_PER_BIT = 868;    // 100 MHz / 115200 baud
   localparam logic [7:0] DEF_SYNC_BYTE    = 8'h55;
   localparam int         DEF_SYNC_LEN     = 6;
   localparam int         DATA_LEN         = 6;      // x, y, z as little-endian 16-bit words

   typedef enum logic [2:0] {
      BYTE_IDLE,
      BYTE_START,
      BYTE_DATA,
      BYTE_STOP,
      BYTE_WAIT_IDLE
   } byte_state_t;

   typedef enum logic [1:0] {
      PAR_HUNT,
      PAR_DATA,
      PAR_TRAILER
   } parser_state_t;

endpackage

// File: rtl/gyro_frame_rx_if.sv
// rtl/gyro_frame_rx_if.sv - output bundle of the gyro frame receiver
// Purpose: groups the decoded sample outputs and byte-level status.
// Ports (signals):
//   x_axis_data/y_axis_data/z_axis_data [15:0]  last accepted samples
//   valid        one-cycle pulse when x/y/z update
//   byte_data    [7:0] last received byte
//   byte_valid   one-cycle pulse per good byte
//   frame_err    one-cycle pulse on bad stop bit
//   synced       high while locked to frame alignment
// Modports: master drives (receiver), slave consumes.
interface gyro_frame_rx_if;

   logic [15:0] x_axis_data;
   logic [15:0] y_axis_data;
   logic [15:0] z_axis_data;
   logic        valid;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        frame_err;
   logic        synced;

   modport master (
      output x_axis_data, y_axis_data, z_axis_data, valid,
             byte_data, byte_valid, frame_err, synced
   );

   modport slave (
      input  x_axis_data, y_axis_data, z_axis_data, valid,
             byte_data, byte_valid, frame_err, synced
   );

endinterface

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with glitch rejection
// Purpose: synchronizes rx, detects start edges, samples mid-bit, reports
//          good bytes and stop-bit errors.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   rx         serial line, idle high, LSB first, asynchronous to clk
//   data       [7:0] last good byte
//   valid      one-cycle pulse, one cycle after a good stop sample
//   frame_err  one-cycle pulse, one cycle after a bad stop sample
module uart_rx_byte
   import gyro_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic rx_meta, rx_s, rx_prev;

   byte_state_t   state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic [7:0]    data_nxt;
   logic          valid_nxt, ferr_nxt;

   // Synchronizer flops idle high so reset never looks like a start edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= BYTE_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shreg     <= shreg_nxt;
         data      <= data_nxt;
         valid     <= valid_nxt;
         frame_err <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      data_nxt    = data;
      valid_nxt   = 1'b0;
      ferr_nxt    = 1'b0;

      case (state)
         BYTE_IDLE: begin
            cnt_nxt = '0;
            if (rx_prev && !rx_s) state_nxt = BYTE_START;
         end
         BYTE_START: begin
            // Mid-start re-check: a line back high here was only a glitch.
            if (cnt == HALF_LAST) begin
               cnt_nxt     = '0;
               bit_idx_nxt = '0;
               state_nxt   = rx_s ? BYTE_IDLE : BYTE_DATA;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         BYTE_DATA: begin
            if (cnt == FULL_LAST) begin
               cnt_nxt   = '0;
               shreg_nxt = {rx_s, shreg[7:1]};
               if (bit_idx == 3'd7) state_nxt = BYTE_STOP;
               else                 bit_idx_nxt = bit_idx + 3'd1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         BYTE_STOP: begin
            if (cnt == FULL_LAST) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  data_nxt  = shreg;
                  valid_nxt = 1'b1;
                  state_nxt = BYTE_IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = BYTE_WAIT_IDLE;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         BYTE_WAIT_IDLE: begin
            cnt_nxt = '0;
            if (rx_s) state_nxt = BYTE_IDLE;
         end
         default: state_nxt = BYTE_IDLE;
      endcase
   end

endmodule

// File: rtl/gyro_frame_rx.sv
// rtl/gyro_frame_rx.sv - gyro UART frame parser with trailer-based alignment
// Purpose: assembles 16-bit x/y/z samples from framed UART bytes, locking on
//          a run of sync bytes and checking the trailer of every frame.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   rx     UART serial line
//   bus    gyro_frame_rx_if.master: samples, valid, byte status, synced
module gyro_frame_rx
   import gyro_uart_pkg::*;
#(
   parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
   parameter int         SYNC_LEN     = DEF_SYNC_LEN
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx,
   gyro_frame_rx_if.master    bus
);

   localparam logic [2:0] RUN_MAX  = 3'(SYNC_LEN);
   localparam logic [2:0] LAST_IDX = 3'(DATA_LEN - 1);

   logic [7:0] rx_data;
   logic       rx_valid, rx_ferr;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .data      (rx_data),
      .valid     (rx_valid),
      .frame_err (rx_ferr)
   );

   parser_state_t pstate, pstate_nxt;
   logic [2:0]    run, run_nxt;      // sync run in HUNT, trailer count in TRAILER
   logic [2:0]    idx, idx_nxt;
   logic [39:0]   stage, stage_nxt;  // first five payload bytes, oldest at [7:0]
   logic [15:0]   x_q, y_q, z_q, x_nxt, y_nxt, z_nxt;
   logic          valid_q, valid_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pstate  <= PAR_HUNT;
         run     <= '0;
         idx     <= '0;
         stage   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         pstate  <= pstate_nxt;
         run     <= run_nxt;
         idx     <= idx_nxt;
         stage   <= stage_nxt;
         x_q     <= x_nxt;
         y_q     <= y_nxt;
         z_q     <= z_nxt;
         valid_q <= valid_nxt;
      end
   end

   always_comb begin
      pstate_nxt = pstate;
      run_nxt    = run;
      idx_nxt    = idx;
      stage_nxt  = stage;
      x_nxt      = x_q;
      y_nxt      = y_q;
      z_nxt      = z_q;
      valid_nxt  = 1'b0;

      if (rx_ferr) begin
         // A corrupted byte breaks alignment; staged bytes are simply abandoned.
         pstate_nxt = PAR_HUNT;
         run_nxt    = '0;
         idx_nxt    = '0;
      end else if (rx_valid) begin
         case (pstate)
            PAR_HUNT: begin
               if (rx_data == SYNC_BYTE) begin
                  if (run != RUN_MAX) run_nxt = run + 3'd1;
               end else if (run == RUN_MAX) begin
                  stage_nxt  = {rx_data, stage[39:8]};
                  idx_nxt    = 3'd1;
                  pstate_nxt = PAR_DATA;
               end else begin
                  run_nxt = '0;
               end
            end
            PAR_DATA: begin
               if (idx == LAST_IDX) begin
                  x_nxt      = stage[15:0];
                  y_nxt      = stage[31:16];
                  z_nxt      = {rx_data, stage[39:32]};
                  valid_nxt  = 1'b1;
                  run_nxt    = '0;
                  idx_nxt    = '0;
                  pstate_nxt = PAR_TRAILER;
               end else begin
                  stage_nxt = {rx_data, stage[39:8]};
                  idx_nxt   = idx + 3'd1;
               end
            end
            PAR_TRAILER: begin
               if (rx_data != SYNC_BYTE) begin
                  run_nxt    = '0;
                  pstate_nxt = PAR_HUNT;
               end else if (run == RUN_MAX - 3'd1) begin
                  run_nxt    = '0;
                  idx_nxt    = '0;
                  pstate_nxt = PAR_DATA;
               end else begin
                  run_nxt = run + 3'd1;
               end
            end
            default: begin
               run_nxt    = '0;
               pstate_nxt = PAR_HUNT;
            end
         endcase
      end
   end

   assign bus.x_axis_data = x_q;
   assign bus.y_axis_data = y_q;
   assign bus.z_axis_data = z_q;
   assign bus.valid       = valid_q;
   assign bus.byte_data   = rx_data;
   assign bus.byte_valid  = rx_valid;
   assign bus.frame_err   = rx_ferr;
   assign bus.synced      = (pstate != PAR_HUNT);

endmodule

// File: tb/tb_gyro_frame_rx.sv
// tb/tb_gyro_frame_rx.sv - self-checking bench for gyro_frame_rx
module tb_gyro_frame_rx;

   localparam int CPB = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic rx    = 1'b1;

   always #5 clk = ~clk;

   gyro_frame_rx_if bus ();

   gyro_frame_rx #(
      .CLKS_PER_BIT (CPB),
      .SYNC_BYTE    (8'h55),
      .SYNC_LEN     (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   bv_cnt      = 0;
   int   fe_cnt      = 0;
   int   valid_cnt   = 0;
   int   push_cnt    = 0;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Output monitor: pops the scoreboard on every sample update.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.byte_valid) bv_cnt++;
         if (bus.frame_err)  fe_cnt++;
         if (bus.valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", {bus.x_axis_data, bus.y_axis_data, bus.z_axis_data}, 48'h0);
               if ({bus.x_axis_data, bus.y_axis_data, bus.z_axis_data} == 48'h0)
                  chk("unexpected_valid_flag", 48'd1, 48'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("x_axis", {32'h0, bus.x_axis_data}, {32'h0, e.x});
               chk("y_axis", {32'h0, bus.y_axis_data}, {32'h0, e.y});
               chk("z_axis", {32'h0, bus.z_axis_data}, {32'h0, e.z});
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_sync(input int n);
      for (int i = 0; i < n; i++) send_byte(8'h55, 1'b1);
   endtask

   // Sends six payload bytes; pushes the expected samples when a lock is expected.
   task automatic send_frame(input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] z, input bit expect_valid);
      exp_t e;
      if (expect_valid) begin
         e.x = x; e.y = y; e.z = z;
         exp_q.push_back(e);
         push_cnt++;
      end
      send_byte(x[7:0], 1'b1);  send_byte(x[15:8], 1'b1);
      send_byte(y[7:0], 1'b1);  send_byte(y[15:8], 1'b1);
      send_byte(z[7:0], 1'b1);  send_byte(z[15:8], 1'b1);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_x"},      {32'h0, bus.x_axis_data}, 48'h0);
      chk({tag, "_y"},      {32'h0, bus.y_axis_data}, 48'h0);
      chk({tag, "_z"},      {32'h0, bus.z_axis_data}, 48'h0);
      chk({tag, "_valid"},  {47'h0, bus.valid},       48'h0);
      chk({tag, "_bdata"},  {40'h0, bus.byte_data},   48'h0);
      chk({tag, "_bvalid"}, {47'h0, bus.byte_valid},  48'h0);
      chk({tag, "_ferr"},   {47'h0, bus.frame_err},   48'h0);
      chk({tag, "_synced"}, {47'h0, bus.synced},      48'h0);
   endtask

   initial begin
      int bv0, fe0;

      // Reset state
      repeat (5) @(negedge clk);
      chk_outputs_zero("reset");
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // Acquisition and first locked frame
      send_sync(6);
      chk("hunt_synced", {47'h0, bus.synced}, 48'h0);
      send_frame(16'h1234, 16'h5678, 16'h9ABC, 1'b1);
      chk("lock_synced", {47'h0, bus.synced}, 48'h1);
      send_sync(6);
      chk("bytedata_last", {40'h0, bus.byte_data}, 48'h55);

      // 0x55 payload bytes are legal once locked
      send_frame(16'h5555, 16'h8000, 16'h7FFF, 1'b1);
      send_sync(6);
      chk("sync_held", {47'h0, bus.synced}, 48'h1);

      // Bad trailer byte drops lock
      send_frame(16'h2211, 16'h4433, 16'h6655, 1'b1);
      send_sync(3);
      chk("trailer_pre_synced", {47'h0, bus.synced}, 48'h1);
      send_byte(8'h54, 1'b1);
      chk("trailer_bad_synced", {47'h0, bus.synced}, 48'h0);
      send_sync(2);
      send_frame(16'h0201, 16'h0403, 16'h0605, 1'b0);
      chk("hunt_no_lock_synced", {47'h0, bus.synced}, 48'h0);
      send_sync(6);
      send_frame(16'h0B0A, 16'h0D0C, 16'h0F0E, 1'b1);
      send_sync(6);
      chk("relock_synced", {47'h0, bus.synced}, 48'h1);

      // Stop bit forced low on y[7:0]
      bv0 = bv_cnt; fe0 = fe_cnt;
      send_byte(8'h21, 1'b1);
      send_byte(8'h43, 1'b1);
      send_byte(8'h65, 1'b0);
      chk("stoperr_ferr",   48'(fe_cnt - fe0), 48'd1);
      chk("stoperr_bvalid", 48'(bv_cnt - bv0), 48'd2);
      chk("stoperr_synced", {47'h0, bus.synced}, 48'h0);
      chk("stoperr_hold", {bus.x_axis_data, bus.y_axis_data, bus.z_axis_data},
          48'h0B0A_0D0C_0F0E);
      send_sync(6);
      send_frame(16'h2010, 16'h4030, 16'h6050, 1'b1);
      send_sync(6);

      // Short low glitch is rejected
      bv0 = bv_cnt; fe0 = fe_cnt;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_bvalid", 48'(bv_cnt - bv0), 48'd0);
      chk("glitch_ferr",   48'(fe_cnt - fe0), 48'd0);

      // Reset asserted during data bit 3
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      rx = 1'b1; repeat (CPB) @(negedge clk);
      rx = 1'b0; repeat (CPB) @(negedge clk);
      rx = 1'b1; repeat (CPB) @(negedge clk);
      rx = 1'b0; repeat (CPB / 2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk_outputs_zero("midbyte_reset");
      rx = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      send_sync(6);
      send_frame(16'hBEEF, 16'hCAFE, 16'h0123, 1'b1);
      send_sync(6);
      send_frame(16'h4567, 16'h89AB, 16'hCDEF, 1'b1);
      send_sync(6);
      chk("final_synced", {47'h0, bus.synced}, 48'h1);

      repeat (20) @(negedge clk);
      chk("scoreboard_empty", 48'(exp_q.size()), 48'd0);
      chk("valid_count", 48'(valid_cnt), 48'(push_cnt));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gyro_frame_rx.md
GYRO_FRAME_RX -- requirements
Module: gyro_frame_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200 baud).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'h55, meaning the trailer fill byte.
REQ-003 SHALL have parameter SYNC_LEN, default 6, meaning the number of trailer bytes per frame.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx  input  1  UART serial line, idle high, 8N1, LSB first; asynchronous to clk.
REQ-007 x_axis_data  output  16  last accepted X sample.
REQ-008 y_axis_data  output  16  last accepted Y sample.
REQ-009 z_axis_data  output  16  last accepted Z sample.
REQ-010 valid  output  1  one-cycle pulse when x/y/z update.
REQ-011 byte_data  output  8  last received byte.
REQ-012 byte_valid  output  1  one-cycle pulse per good byte.
REQ-013 frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-014 synced  output  1  high while the parser is locked to frame alignment.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer before any use; all timing below is relative to the synchronized signal.
REQ-016 Byte receiver states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-017 IDLE->START on a synchronized falling edge; START re-samples at CLKS_PER_BIT/2, returning to IDLE if the line is high (glitch rejected).
REQ-018 DATA SHALL sample 8 bits at CLKS_PER_BIT intervals from mid-start, LSB first; STOP samples one further interval later.
REQ-019 Stop bit = 1: byte_data updates and byte_valid pulses 1 cycle after the stop sample, then IDLE.
REQ-020 Stop bit = 0: frame_err pulses, the byte is discarded, and the state goes to WAIT_IDLE until the line is high.
REQ-021 Frame layout SHALL be x[7:0], x[15:8], y[7:0], y[15:8], z[7:0], z[15:8] followed by SYNC_LEN x SYNC_BYTE; 12 bytes total at default.
REQ-022 Parser states SHALL be HUNT, DATA, TRAILER.
REQ-023 HUNT: a 3-bit run counter increments on SYNC_BYTE (saturating at SYNC_LEN) and clears on any other byte.
REQ-024 HUNT: a non-SYNC_BYTE byte arriving with run==SYNC_LEN is taken as x[7:0]; the state goes to DATA at index 1.
REQ-025 DATA: the next 6 bytes are stored regardless of value (0x55 data is legal once locked).
REQ-026 On the z[15:8] byte, all three outputs SHALL update together and valid pulses in the same cycle, i.e. 1 cycle after that byte_valid; the state goes to TRAILER.
REQ-027 TRAILER: exactly SYNC_LEN SYNC_BYTEs are required, then the state goes to DATA at index 0; any other byte clears synced and returns to HUNT with run=0.
REQ-028 frame_err while in DATA or TRAILER SHALL drop to HUNT, run=0, with partial data discarded and outputs unchanged.
REQ-029 synced SHALL be high in DATA and TRAILER and low in HUNT.
REQ-030 Acquisition limitation (accepted): lock is not gained from HUNT on a frame whose x[7:0]==SYNC_BYTE; the next frame locks.

Reset
REQ-031 reset low SHALL asynchronously force IDLE/HUNT, synchronizer flops to 1, all counters to 0, all data outputs to 0, and all pulses and synced to 0.
REQ-032 reset asserted mid-byte SHALL discard that byte; after release, the first valid start edge begins a fresh byte.

Structure
REQ-033 Package gyro_uart_pkg SHALL hold the CLKS_PER_BIT default, SYNC_BYTE, SYNC_LEN, DATA_LEN=6, and the byte and parser state enums.
REQ-034 The byte receiver SHALL be sub-module uart_rx_byte (clk, reset, rx, data, valid, frame_err); gyro_frame_rx holds the parser and output registers.

Verification (bench uses CLKS_PER_BIT=16)
REQ-035 Locked stream: 6x55 then 34 12 78 56 BC 9A + 6x55 -> valid once; x=1234, y=5678, z=9ABC; synced=1.
REQ-036 Locked, next frame data 55 55 00 80 FF 7F -> x=5555, y=8000, z=7FFF; sync held.
REQ-037 Trailer byte 4 = 0x54 -> synced falls 1 cycle after that byte_valid; no valid until 6x55 + non-55 x[7:0] re-acquires.
REQ-038 Stop bit forced 0 on y[7:0] -> frame_err pulse, no byte_valid, synced=0, outputs hold previous values.
REQ-039 Low glitch on rx of 4 cycles (< CLKS_PER_BIT/2) -> no byte_valid, no frame_err.
REQ-040 reset pulsed low during DATA bit 3 -> all outputs 0 immediately; the following clean frame pair decodes correctly.
